// File: rtl/mem_if_pkg.sv
// Shared definitions for the line-based memory request interface.
// Used by both the processor-side requester and the memory-side responder.
//   - Line geometry constants (words per line, word/line/address widths).
//   - Responder FSM state encoding.
//   - Counter width for the fixed-latency wait.
package mem_if_pkg;

    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 16;
    localparam int LINE_W     = LINE_WORDS * WORD_W;  // 64
    localparam int ADDR_W     = 16;

    // Latency counter holds LATENCY-1, so 8 bits covers LATENCY up to 255.
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage : mem_if_pkg

// File: rtl/mem_line_array.sv
// Single-port line storage for the memory responder.
//   clk     : rising-edge clock
//   rst     : async active-high reset, clears only the read-data register
//   en      : access enable (one cycle per request, on its completing edge)
//   we      : 1 = write wr_data into line idx, 0 = read line idx into rd_data
//   idx     : line index
//   wr_data : line to write
//   rd_data : registered read line; holds its value until the next read
// The storage itself has no reset, so its contents survive rst.
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int LINE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [LINE_BITS-1:0] idx,
    input  logic [LINE_W-1:0]    wr_data,
    output logic [LINE_W-1:0]    rd_data
);

    localparam int DEPTH = 1 << LINE_BITS;

    logic [LINE_W-1:0] mem [DEPTH];

    logic [LINE_W-1:0] rd_data_q;
    logic [LINE_W-1:0] rd_data_d;

    // Storage write: no reset so the contents persist across rst.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wr_data;
        end
    end

    // Read register only updates on a read access; writes leave it alone.
    always_comb begin
        rd_data_d = rd_data_q;
        if (en && !we) begin
            rd_data_d = mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : mem_line_array

// File: rtl/mem_responder.sv
// Memory-side responder for the line-based request interface.
// Serves one request at a time with a fixed latency and a one-cycle
// completion pulse.
//   clk       : rising-edge clock
//   rst       : async active-high reset
//   startReq  : request strobe, sampled only in IDLE
//   isRd      : 1 = read line, 0 = write line (sampled with startReq)
//   inAddr    : word address; line index = inAddr[LINE_BITS+1:2]
//   inData    : write line data (sampled with startReq)
//   outData   : registered read data, changes only when a read completes
//   reqFinish : one-cycle completion pulse for reads and writes
//   busy      : high whenever the FSM is not IDLE
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and startReq is high; the request inputs are captured at that edge and
// ignored until the FSM returns to IDLE. Acceptance at edge k raises
// reqFinish at edge k+LATENCY for exactly one cycle, so accepted requests
// are at least LATENCY+2 edges apart.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startReq,
    input  logic              isRd,
    input  logic [ADDR_W-1:0] inAddr,
    input  logic [LINE_W-1:0] inData,
    output logic [LINE_W-1:0] outData,
    output logic              reqFinish,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    mem_state_e state_q, state_d;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rd_q, rd_d;
    logic [LINE_BITS-1:0] idx_q, idx_d;
    logic [LINE_W-1:0]    data_q, data_d;
    logic                 req_finish_q, req_finish_d;

    logic                 arr_en;
    logic [LINE_BITS-1:0] addr_idx;

    // Word-select bits and high alias bits are intentionally dropped.
    logic                 unused_addr;

    assign addr_idx    = inAddr[LINE_BITS+1:2];
    assign unused_addr = ^inAddr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            idx_q        <= '0;
            data_q       <= '0;
            req_finish_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            req_finish_q <= req_finish_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, latency counter and request capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        data_d  = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (startReq) begin
                    rd_d    = isRd;
                    idx_d   = addr_idx;
                    data_d  = inData;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        // The access and the completion pulse both launch on the
        // WAIT->DONE edge, so read data and reqFinish appear together.
        arr_en       = (state_q == ST_WAIT) && (cnt_q == '0);
        req_finish_d = arr_en;
    end

    assign reqFinish = req_finish_q;
    assign busy      = (state_q != ST_IDLE);

    mem_line_array #(
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .en      (arr_en),
        .we      (!rd_q),
        .idx     (idx_q),
        .wr_data (data_q),
        .rd_data (outData)
    );

endmodule : mem_responder

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's line-based request interface (startReq/isRd/inAddr/inData -> outData/reqFinish).
- One instance serves the data port and one serves the instruction port in the top-level test harness.
- Holds 64-bit lines (4 x 16-bit words) in an internal array.
- Services one request at a time with a fixed, parameterised latency and a one-cycle completion pulse.

Parameters:
- LATENCY, 4, edges from request acceptance to the edge that raises reqFinish; legal range 1..255.
- LINE_BITS, 8, log2 of line count; array holds 2^LINE_BITS x 64 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- startReq  input  1  request strobe (level); sampled only in IDLE
- isRd  input  1  1 = read line, 0 = write line; sampled with startReq
- inAddr  input  16  16-bit word address; line index = inAddr[LINE_BITS+1:2]
- inData  input  64  write line data; sampled with startReq
- outData  output  64  read line data, registered
- reqFinish  output  1  one-cycle completion pulse, reads and writes
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - State = IDLE, counter = 0, outData = 0, reqFinish = 0, busy = 0.
  - Array contents are not reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with startReq=1: latch isRd, line index and inData; set cnt = LATENCY-1; go to WAIT.
  - Otherwise remain in IDLE.
- WAIT:
  - If cnt != 0: decrement cnt and stay in WAIT.
  - If cnt == 0, at that edge:
    - Read: outData <= array[idx].
    - Write: array[idx] <= latched data; outData unchanged.
    - reqFinish <= 1; go to DONE.
- DONE:
  - reqFinish high for exactly this cycle.
  - Next edge: reqFinish <= 0; go to IDLE.
- Latency:
  - Request accepted at edge k -> reqFinish high from edge k+LATENCY to edge k+LATENCY+1.
  - Minimum spacing between accepted requests is LATENCY+2 edges.
- Request inputs:
  - startReq, isRd, inAddr and inData are ignored in WAIT and DONE.
  - Changes to them after acceptance do not affect the request in flight.
- Requester handshake:
  - Requester drops startReq in the reqFinish cycle.
  - If startReq is still high in the first IDLE cycle, a new request is accepted there (defined, not an error).
- Addressing:
  - inAddr[1:0] is ignored; accesses are always a whole line.
  - inAddr bits above LINE_BITS+1 are ignored, so addresses alias modulo 2^(LINE_BITS+2) words.
- outData:
  - Holds its last value until the next read completes.
  - Write completions never change it.
- Write-then-read to the same line returns the new data; no forwarding is needed because requests are serialised.
- Reset mid-operation:
  - Any write whose completing edge has not yet occurred is dropped; the array is unchanged.
  - reqFinish is forced to 0 immediately (async).
- LATENCY=1: WAIT lasts one cycle (cnt starts at 0).

Decomposition:
- Shared package mem_if_pkg:
  - State enum (IDLE/WAIT/DONE).
  - Constants LINE_WORDS=4, WORD_W=16, LINE_W=64, ADDR_W=16.
  - Both processor-side and responder-side code use this package.
- Sub-module mem_line_array:
  - 2^LINE_BITS x 64 single-port array.
  - Synchronous write, synchronous read; enable driven from the WAIT->DONE transition.
  - No reset.
- FSM, counter and request latches stay in mem_responder.

Test Plan (LATENCY=3, LINE_BITS=8 unless stated):
- Reset: assert rst for 2 cycles -> outData=0, reqFinish=0, busy=0; busy stays 0 with startReq=0.
- Write then read:
  - Write 0x1111_2222_3333_4444 to inAddr=0x0010, accepted at edge k -> reqFinish pulses only during cycle k+3..k+4; outData stays 0.
  - Read inAddr=0x0013 -> outData=0x1111_2222_3333_4444 at reqFinish.
- Aliasing: write 0xDEAD_BEEF_0000_0001 to 0x0004, read 0x0404 -> same data (index bits 9:2 match).
- Input changes ignored: during WAIT toggle isRd/inAddr/inData and hold startReq high -> in-flight result unchanged; second request accepted in first IDLE cycle after DONE.
- Reset mid-write: accept a write to line 5 (old 0xAAAA...), assert rst at edge k+1 -> reqFinish never pulses; a later read of line 5 returns the old value.
- LATENCY=1 instance: read accepted at edge k -> reqFinish high k+1..k+2; back-to-back held startReq yields requests every 3 edges.
